ifill_router: RTL and testbench

Instruction-refill router between the core tile's icache miss port and the two refill sources: the boot ROM and the L2. It replaces the combinational response mux in the simulation top. It decodes each line-fill request by physical address and forwards it to exactly one source, with one request outstanding at a time. It registers the returned line, applies a watchdog timeout, and discards responses belonging to flushed or timed-out requests.

---
 rtl/ifill_router.sv | 146 ++++++++++++++
 tb/tb_ifill_router.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifill_router.sv
// Instruction-refill router: steers each icache line fill to the boot ROM or the L2,
// keeps one request in flight, applies a watchdog and drops flushed/late responses.
module ifill_router #(
  parameter int unsigned     PADDR_W     = 40,
  parameter int unsigned     LINE_W      = 128,
  parameter int unsigned     BROM_ADDR_W = 24,
  parameter longint unsigned BROM_LIMIT  = 64'h10000,
  parameter int unsigned     TIMEOUT     = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,

  input  logic                   ic_req_valid_i,
  input  logic [PADDR_W-1:0]     ic_req_paddr_i,
  output logic                   ic_req_ready_o,
  output logic                   ic_resp_valid_o,
  output logic [LINE_W-1:0]      ic_resp_data_o,
  output logic                   ic_resp_error_o,
  input  logic                   flush_i,

  output logic                   brom_req_valid_o,
  output logic [BROM_ADDR_W-1:0] brom_req_address_o,
  input  logic                   brom_resp_valid_i,
  input  logic [LINE_W-1:0]      brom_resp_data_i,

  output logic                   l2_req_valid_o,
  output logic [PADDR_W-1:0]     l2_req_paddr_o,
  input  logic                   l2_resp_valid_i,
  input  logic [LINE_W-1:0]      l2_resp_data_i,

  output logic                   busy_o,
  output logic                   stray_o
);

  localparam int unsigned        CNT_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [PADDR_W-1:0] LIMIT      = PADDR_W'(BROM_LIMIT);
  localparam logic [PADDR_W-1:0] ALIGN_MASK = ~PADDR_W'(LINE_W / 8 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BROM_WAIT,
    S_L2_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t               r_state;
  logic                 r_to_brom;
  logic [PADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_brom_req;
  logic                 r_l2_req;
  logic [LINE_W-1:0]    r_resp_data;
  logic                 r_resp_error;
  logic                 r_stray;

  logic [PADDR_W-1:0]   w_aligned;
  logic                 w_accept;
  logic                 w_to_brom;
  logic                 w_brom_take;
  logic                 w_l2_take;
  logic                 w_timeout;
  logic                 w_stray;

  assign ic_req_ready_o = (r_state == S_IDLE) & ~flush_i;
  assign w_accept       = ic_req_valid_i & ic_req_ready_o;
  assign w_aligned      = ic_req_paddr_i & ALIGN_MASK;
  assign w_to_brom      = (w_aligned < LIMIT);
  assign w_timeout      = (r_cnt == CNT_LAST);

  // A response is consumed only by the state waiting on that source; everything else is stray.
  assign w_brom_take = brom_resp_valid_i &
                       ((r_state == S_BROM_WAIT) | ((r_state == S_DRAIN) & r_to_brom));
  assign w_l2_take   = l2_resp_valid_i &
                       ((r_state == S_L2_WAIT) | ((r_state == S_DRAIN) & ~r_to_brom));
  assign w_stray     = (brom_resp_valid_i & ~w_brom_take) | (l2_resp_valid_i & ~w_l2_take);

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_to_brom    <= 1'b0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_brom_req   <= 1'b0;
      r_l2_req     <= 1'b0;
      r_resp_data  <= '0;
      r_resp_error <= 1'b0;
      r_stray      <= 1'b0;
    end else begin
      r_brom_req <= 1'b0;
      r_l2_req   <= 1'b0;
      if (w_stray) r_stray <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr     <= w_aligned;
            r_cnt      <= '0;
            r_to_brom  <= w_to_brom;
            r_brom_req <= w_to_brom;
            r_l2_req   <= ~w_to_brom;
            r_state    <= w_to_brom ? S_BROM_WAIT : S_L2_WAIT;
          end
        end

        S_BROM_WAIT, S_L2_WAIT: begin
          // Saturate so a flush on the final wait cycle still leaves DRAIN promptly.
          if (!w_timeout) r_cnt <= r_cnt + CNT_W'(1);
          if (flush_i) begin
            r_state <= S_DRAIN;
          end else if (w_brom_take | w_l2_take) begin
            r_resp_data  <= (r_state == S_BROM_WAIT) ? brom_resp_data_i : l2_resp_data_i;
            r_resp_error <= 1'b0;
            r_state      <= S_RESP;
          end else if (w_timeout) begin
            r_resp_data  <= '0;
            r_resp_error <= 1'b1;
            r_state      <= S_RESP;
          end
        end

        S_DRAIN: begin
          if (!w_timeout) r_cnt <= r_cnt + CNT_W'(1);
          if (w_brom_take | w_l2_take | w_timeout) r_state <= S_IDLE;
        end

        S_RESP: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ic_resp_valid_o    = (r_state == S_RESP) & ~flush_i;
  assign ic_resp_data_o     = r_resp_data;
  assign ic_resp_error_o    = r_resp_error;
  assign brom_req_valid_o   = r_brom_req;
  assign brom_req_address_o = r_addr[BROM_ADDR_W-1:0];
  assign l2_req_valid_o     = r_l2_req;
  assign l2_req_paddr_o     = r_addr;
  assign busy_o             = (r_state != S_IDLE);
  assign stray_o            = r_stray;

endmodule

// File: tb/tb_ifill_router.sv
// Self-checking bench for ifill_router: directed scenarios plus randomized transactions
// compared against a transaction-level timing model.
module tb_ifill_router;

  localparam int PADDR_W     = 40;
  localparam int LINE_W      = 128;
  localparam int BROM_ADDR_W = 24;
  localparam int TIMEOUT     = 8;
  localparam logic [39:0] LIMIT = 40'h10000;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   ic_req_valid_i;
  logic [PADDR_W-1:0]     ic_req_paddr_i;
  logic                   ic_req_ready_o;
  logic                   ic_resp_valid_o;
  logic [LINE_W-1:0]      ic_resp_data_o;
  logic                   ic_resp_error_o;
  logic                   flush_i;
  logic                   brom_req_valid_o;
  logic [BROM_ADDR_W-1:0] brom_req_address_o;
  logic                   brom_resp_valid_i;
  logic [LINE_W-1:0]      brom_resp_data_i;
  logic                   l2_req_valid_o;
  logic [PADDR_W-1:0]     l2_req_paddr_o;
  logic                   l2_resp_valid_i;
  logic [LINE_W-1:0]      l2_resp_data_i;
  logic                   busy_o;
  logic                   stray_o;

  ifill_router #(
    .PADDR_W(PADDR_W), .LINE_W(LINE_W), .BROM_ADDR_W(BROM_ADDR_W),
    .BROM_LIMIT(64'h10000), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ic_req_valid_i(ic_req_valid_i), .ic_req_paddr_i(ic_req_paddr_i), .ic_req_ready_o(ic_req_ready_o),
    .ic_resp_valid_o(ic_resp_valid_o), .ic_resp_data_o(ic_resp_data_o), .ic_resp_error_o(ic_resp_error_o),
    .flush_i(flush_i),
    .brom_req_valid_o(brom_req_valid_o), .brom_req_address_o(brom_req_address_o),
    .brom_resp_valid_i(brom_resp_valid_i), .brom_resp_data_i(brom_resp_data_i),
    .l2_req_valid_o(l2_req_valid_o), .l2_req_paddr_o(l2_req_paddr_o),
    .l2_resp_valid_i(l2_resp_valid_i), .l2_resp_data_i(l2_resp_data_i),
    .busy_o(busy_o), .stray_o(stray_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;
  bit exp_stray = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ic_req_valid_i    = 1'b0;
    ic_req_paddr_i    = '0;
    flush_i           = 1'b0;
    brom_resp_valid_i = 1'b0;
    brom_resp_data_i  = '0;
    l2_resp_valid_i   = 1'b0;
    l2_resp_data_i    = '0;
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [39:0] rand_paddr();
    logic [39:0] a;
    case ($urandom_range(0, 2))
      0:       a = {24'b0, 16'($urandom)};
      1:       a = 40'h10000 + 40'($urandom_range(0, 255)) - 40'h10;
      default: a = {8'($urandom), 32'($urandom)};
    endcase
    return a;
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    clear_inputs();
    @(negedge clk_i);
    #1;
    check("rst_resp_valid", ic_resp_valid_o, 0);
    check("rst_resp_data",  ic_resp_data_o, 0);
    check("rst_resp_error", ic_resp_error_o, 0);
    check("rst_brom_req",   brom_req_valid_o, 0);
    check("rst_brom_addr",  brom_req_address_o, 0);
    check("rst_l2_req",     l2_req_valid_o, 0);
    check("rst_l2_addr",    l2_req_paddr_o, 0);
    check("rst_busy",       busy_o, 0);
    check("rst_stray",      stray_o, 0);
    check("rst_ready",      ic_req_ready_o, 1);
    rst_i = 1'b0;
    exp_stray = 1'b0;
  endtask

  // One transaction. d: response delay after the source pulse (-1 = never);
  // fd: flush delay after the pulse (-1 = none); ws: wrong-source strobe delay (-1 = none).
  task automatic run_txn(input logic [39:0] paddr, input int d, input int fd, input int ws,
                         input logic [127:0] data);
    logic [39:0] al;
    bit          to_brom;
    int          resp_c, idle_c, wsc;
    bit          err;
    al      = paddr & ~40'hF;
    to_brom = (al < LIMIT);
    err     = 1'b0;
    if (fd >= 0) begin
      resp_c = -1;
      idle_c = (d >= 0) ? d + 2 : TIMEOUT + 1;
    end else if (d >= 0) begin
      resp_c = d + 2;
      idle_c = d + 3;
    end else begin
      resp_c = TIMEOUT + 1;
      idle_c = TIMEOUT + 2;
      err    = 1'b1;
    end
    wsc = (ws < 0) ? -1 : ((ws + 1 > idle_c) ? idle_c : ws + 1);
    if (wsc >= 0) exp_stray = 1'b1;

    @(negedge clk_i);
    ic_req_valid_i = 1'b1;
    ic_req_paddr_i = paddr;
    #1;
    check("req_ready", ic_req_ready_o, 1);
    for (int c = 1; c <= idle_c; c++) begin
      @(negedge clk_i);
      ic_req_valid_i    = 1'b0;
      flush_i           = (c == fd + 1) && (fd >= 0);
      brom_resp_valid_i = 1'b0;
      l2_resp_valid_i   = 1'b0;
      if (d >= 0 && c == d + 1) begin
        if (to_brom) begin brom_resp_valid_i = 1'b1; brom_resp_data_i = data; end
        else begin l2_resp_valid_i = 1'b1; l2_resp_data_i = data; end
      end
      if (c == wsc) begin
        if (to_brom) begin l2_resp_valid_i = 1'b1; l2_resp_data_i = rand_line(); end
        else begin brom_resp_valid_i = 1'b1; brom_resp_data_i = rand_line(); end
      end
      #1;
      check("brom_req_pulse", brom_req_valid_o, (c == 1) && to_brom);
      check("l2_req_pulse",   l2_req_valid_o,   (c == 1) && !to_brom);
      check("ic_resp_valid",  ic_resp_valid_o,  c == resp_c);
      check("busy",           busy_o,           c < idle_c);
      check("ready",          ic_req_ready_o,   c == idle_c);
      if (c == 1) begin
        check("brom_addr", brom_req_address_o, al[23:0]);
        check("l2_paddr",  l2_req_paddr_o, al);
      end
      if (c == resp_c) begin
        check("resp_data",  ic_resp_data_o, err ? 128'd0 : data);
        check("resp_error", ic_resp_error_o, err);
      end
    end
    @(negedge clk_i);
    clear_inputs();
    #1;
    check("stray", stray_o, exp_stray);
  endtask

  initial begin
    int d, fd, ws;
    rst_i = 1'b0;
    clear_inputs();

    do_reset();

    run_txn(40'h104, 2, -1, -1, rand_line());
    run_txn(40'h8000_0010, 0, -1, -1, rand_line());
    run_txn(40'hFFF0, 1, -1, -1, rand_line());
    run_txn(40'hFFFF, 3, -1, -1, rand_line());
    run_txn(40'h10000, 1, -1, -1, rand_line());
    run_txn(40'h8000_0000, 4, 1, -1, rand_line());
    run_txn(40'h8000_0040, 7, -1, -1, rand_line());

    for (int i = 0; i < 30; i++) begin
      d  = int'($urandom_range(0, 8));
      if (d == 8) d = -1;
      fd = -1;
      if (d != 0 && $urandom_range(0, 3) == 0)
        fd = int'($urandom_range(0, (d > 0) ? d - 1 : TIMEOUT - 2));
      run_txn(rand_paddr(), d, fd, -1, rand_line());
    end

    run_txn(40'h8000_1000, -1, -1, -1, rand_line());
    @(negedge clk_i);
    l2_resp_valid_i = 1'b1;
    @(negedge clk_i);
    l2_resp_valid_i = 1'b0;
    #1;
    check("late_l2_stray", stray_o, 1);

    do_reset();
    run_txn(40'h9000_0000, 3, -1, 1, rand_line());

    do_reset();
    @(negedge clk_i);
    ic_req_valid_i = 1'b1;
    ic_req_paddr_i = 40'h8000_2000;
    @(negedge clk_i);
    ic_req_valid_i = 1'b0;
    #1;
    check("mid_l2_req", l2_req_valid_o, 1);
    check("mid_busy",   busy_o, 1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_busy",  busy_o, 0);
    check("mid_rst_req",   l2_req_valid_o, 0);
    check("mid_rst_stray", stray_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    l2_resp_valid_i = 1'b1;
    @(negedge clk_i);
    l2_resp_valid_i = 1'b0;
    #1;
    check("post_rst_stray", stray_o, 1);
    exp_stray = 1'b1;

    for (int i = 0; i < 30; i++) begin
      d  = int'($urandom_range(0, 8));
      if (d == 8) d = -1;
      fd = -1;
      if (d != 0 && $urandom_range(0, 3) == 0)
        fd = int'($urandom_range(0, (d > 0) ? d - 1 : TIMEOUT - 2));
      ws = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_txn(rand_paddr(), d, fd, ws, rand_line());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    done = 1'b1;
    $finish;
  end

  final begin
    if (!done) $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
  end

endmodule
